// File: rtl/btn_event_arbiter_if.sv
// Event bus between the button arbiter and its consumer.
// The overrun/ovr_clr pair exists only when BTN_OVERRUN_EN is defined.
interface btn_event_arbiter_if #(
  parameter int N_BTN = 4,
  parameter int ID_W  = 2
);
  logic [N_BTN-1:0] btn_pulse;
  logic             evt_valid;
  logic [ID_W-1:0]  evt_id;
  logic             evt_ready;
  logic [N_BTN-1:0] pending;
`ifdef BTN_OVERRUN_EN
  logic             overrun;
  logic             ovr_clr;

  modport master (
    input  btn_pulse, evt_ready, ovr_clr,
    output evt_valid, evt_id, pending, overrun
  );
  modport slave (
    output btn_pulse, evt_ready, ovr_clr,
    input  evt_valid, evt_id, pending, overrun
  );
`else
  modport master (
    input  btn_pulse, evt_ready,
    output evt_valid, evt_id, pending
  );
  modport slave (
    output btn_pulse, evt_ready,
    input  evt_valid, evt_id, pending
  );
`endif
endinterface

// File: rtl/btn_event_arbiter.sv
// Latches button press pulses as pending events and offers them one at a time,
// round-robin, over a valid/ready handshake. Optional drop flag: BTN_OVERRUN_EN.
//
// state   | meaning
// S_IDLE  | nothing offered; picks a winner from pending flags if any
// S_OFFER | evt_valid held high with a frozen evt_id until the consumer accepts
module btn_event_arbiter #(
  parameter int N_BTN = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  btn_event_arbiter_if.master  bus
);

  typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [N_BTN-1:0] r_pend, w_pend_nxt;
  logic [ID_W-1:0]  r_rr_ptr, w_rr_nxt;
  logic [ID_W-1:0]  r_evt_id, w_id_nxt;
  logic             r_evt_valid, w_valid_nxt;
  logic             w_hs;
  logic [N_BTN-1:0] w_clr;
  logic [N_BTN-1:0] w_mask;
  logic [N_BTN-1:0] w_hi;
  logic [ID_W-1:0]  w_winner;
  logic [ID_W-1:0]  w_id_inc;

  function automatic logic [ID_W-1:0] f_lowest(input logic [N_BTN-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  assign w_hs = r_evt_valid & bus.evt_ready;

  // Round robin: prefer pending bits at or above the pointer, else wrap to the lowest.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_mask[i] = (i >= int'(r_rr_ptr));
    end
    w_hi     = r_pend & w_mask;
    w_winner = (|w_hi) ? f_lowest(w_hi) : f_lowest(r_pend);
  end

  assign w_id_inc = (r_evt_id == ID_W'(N_BTN - 1)) ? '0 : r_evt_id + ID_W'(1);

  always_comb begin
    w_clr = '0;
    w_clr[r_evt_id] = w_hs;
    w_pend_nxt = (r_pend & ~w_clr) | bus.btn_pulse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_rr_ptr    <= '0;
      r_pend      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_evt_valid <= w_valid_nxt;
      r_evt_id    <= w_id_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_pend      <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_evt_valid;
    w_id_nxt    = r_evt_id;
    w_rr_nxt    = r_rr_ptr;
    unique case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_state_nxt = S_OFFER;
          w_valid_nxt = 1'b1;
          w_id_nxt    = w_winner;
        end
      end
      S_OFFER: begin
        if (bus.evt_ready) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_rr_nxt    = w_id_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.evt_valid = r_evt_valid;
  assign bus.evt_id    = r_evt_id;
  assign bus.pending   = r_pend;

`ifdef BTN_OVERRUN_EN
  logic r_overrun;
  logic w_drop;

  // A press on a bit that stays pending this cycle merges into the existing event.
  assign w_drop = |(bus.btn_pulse & r_pend & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_drop | (r_overrun & ~bus.ovr_clr);
    end
  end

  assign bus.overrun = r_overrun;
`endif

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Scoreboard bench for btn_event_arbiter: reference model predicts offered events,
// a monitor pops and compares each time evt_valid rises.
module tb_btn_event_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btn_event_arbiter_if #(.N_BTN(N), .ID_W(W)) bus();

  btn_event_arbiter #(.N_BTN(N), .ID_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];

  bit m_pend[N];
  int m_ptr;
  bit m_offer;
  int m_id;
  bit m_ovr;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pend_word();
    int w;
    w = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) w |= (1 << i);
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_ptr = 0;
    m_offer = 1'b0;
    m_id = 0;
    m_ovr = 1'b0;
    exp_q.delete();
  endtask

  // One clock of the behavioural model: arbitration sees flags from before this edge.
  task automatic model_cycle(input int p, input bit rdy, input bit clr);
    bit old[N];
    int served;
    int c;
    bit drop;
    for (int i = 0; i < N; i++) old[i] = m_pend[i];
    served = -1;
    drop = 1'b0;
    if (m_offer) begin
      if (rdy) begin
        served = m_id;
        m_ptr = (m_id + 1) % N;
        m_offer = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (old[c]) begin
          m_offer = 1'b1;
          m_id = c;
          exp_q.push_back(c);
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i == served) m_pend[i] = 1'b0;
      if (p[i]) begin
        if (old[i] && i != served) drop = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
    m_ovr = drop | (m_ovr & ~clr);
  endtask

  task automatic check_outputs();
    chk("evt_valid", int'(bus.evt_valid), int'(m_offer));
    chk("pending", int'(bus.pending), pend_word());
    if (m_offer) chk("evt_id_hold", int'(bus.evt_id), m_id);
`ifdef BTN_OVERRUN_EN
    chk("overrun", int'(bus.overrun), int'(m_ovr));
`endif
  endtask

  task automatic step(input int p, input bit rdy, input bit clr);
    check_outputs();
    bus.btn_pulse = N'(p);
    bus.evt_ready = rdy;
`ifdef BTN_OVERRUN_EN
    bus.ovr_clr = clr;
`endif
    model_cycle(p, rdy, clr);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.btn_pulse = '0;
    bus.evt_ready = 1'b0;
`ifdef BTN_OVERRUN_EN
    bus.ovr_clr = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit prev_v = 1'b0;
  int sb_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (bus.evt_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected: evt_id %0d offered, expected no event at %0t",
                   bus.evt_id, $time);
        end else begin
          sb_exp = exp_q.pop_front();
          chk("sb_evt_id", int'(bus.evt_id), sb_exp);
        end
      end
      prev_v = bus.evt_valid;
    end
  end

  initial begin
    bus.btn_pulse = '0;
    bus.evt_ready = 1'b0;
`ifdef BTN_OVERRUN_EN
    bus.ovr_clr = 1'b0;
`endif
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    chk("reset_evt_id", int'(bus.evt_id), 0);
    rst_n = 1'b1;

    // single press on button 2
    step(4'b0100, 1'b1, 1'b0);
    repeat (4) step(0, 1'b1, 1'b0);

    // simultaneous presses 0,1,3 from reset order
    apply_reset();
    step(4'b1011, 1'b1, 1'b0);
    repeat (8) step(0, 1'b1, 1'b0);

    // consumer stalls on event 1 while button 0 is pressed; next event wraps to 0
    apply_reset();
    step(4'b0010, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step((i == 5) ? 1 : 0, 1'b0, 1'b0);
    repeat (5) step(0, 1'b1, 1'b0);

    // re-press of button 2 on its own handshake cycle
    apply_reset();
    step(4'b0100, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    repeat (5) step(0, 1'b1, 1'b0);

    // merged presses on button 1, then clear; then set and clear together
    apply_reset();
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0);
    repeat (5) step(0, 1'b1, 1'b0);

    // asynchronous reset while offering
    apply_reset();
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    check_outputs();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_evt_valid", int'(bus.evt_valid), 0);
    chk("async_rst_pending", int'(bus.pending), 0);
`ifdef BTN_OVERRUN_EN
    chk("async_rst_overrun", int'(bus.overrun), 0);
`endif
    model_reset();
    bus.evt_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step(0, 1'b1, 1'b0);

    // randomized traffic
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0));
    end
    repeat (12) step(0, 1'b1, 1'b0);
    check_outputs();
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
